// File: rtl/rpm_meter_if.sv
// rpm_meter_if: measurement enable, Hall input and speed result bundle for rpm_meter
interface rpm_meter_if #(parameter int RPM_W = 11);
   logic             en;
   logic             hall_in;
   logic [RPM_W-1:0] rpm;
   logic             rpm_valid;
   logic             overflow;
   logic             busy;
   modport master (output en, hall_in, input rpm, rpm_valid, overflow, busy);
   modport slave  (input en, hall_in, output rpm, rpm_valid, overflow, busy);
endinterface

// File: rtl/rpm_meter.sv
// rpm_meter: gated Hall-edge count scaled to RPM by a shift-add multiplier; RPM_AVG_EN averages the last 4 results
module rpm_meter #(
   parameter int COUNT_W     = 11,
   parameter int RPM_W       = 11,
   parameter int SCALE       = 10,
   parameter int GATE_CYCLES = 5_000_000
) (
   input  logic         clk,
   input  logic         rst,
   rpm_meter_if.slave   bus
);
   localparam int P  = COUNT_W + RPM_W;
   localparam int GW = $clog2(GATE_CYCLES);
   localparam int KW = $clog2(COUNT_W + 1);
   typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
   state_t             state, nxt;
   logic [2:0]         sync;
   logic               edge_p, term, lat_stb, cnt_max, cnt_sat, lat_sat, last, prod_sat, res_ovf;
   logic [GW-1:0]      gate_cnt;
   logic [COUNT_W-1:0] edge_cnt, latched_cnt, mp;
   logic [P-1:0]       acc, mc, acc_nxt;
   logic [KW-1:0]      k;
   logic [RPM_W-1:0]   res;

   generate
      if (GATE_CYCLES <= COUNT_W + 3 || SCALE < 1 || SCALE >= 2 ** RPM_W) begin : g_bad_params
         $error("rpm_meter: GATE_CYCLES must exceed COUNT_W+3 and SCALE must be 1..2**RPM_W-1");
      end
   endgenerate

   assign term     = bus.en && gate_cnt == GW'(GATE_CYCLES - 1);
   assign cnt_max  = &edge_cnt;
   assign acc_nxt  = acc + (mp[0] ? mc : '0);
   assign last     = k == KW'(COUNT_W - 1);
   assign prod_sat = |acc_nxt[P-1:RPM_W];

   // two-flop Hall synchroniser plus a registered rising-edge pulse
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync   <= '0;
         edge_p <= 1'b0;
      end else begin
         sync   <= {sync[1:0], bus.hall_in};
         edge_p <= sync[1] & ~sync[2];
      end

   // gate window and saturating edge counter; the terminal cycle hands the count (incl. its own edge) to the multiplier
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         gate_cnt    <= '0;
         edge_cnt    <= '0;
         cnt_sat     <= 1'b0;
         latched_cnt <= '0;
         lat_sat     <= 1'b0;
         lat_stb     <= 1'b0;
      end else begin
         lat_stb <= term;
         if (!bus.en || term) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            cnt_sat  <= 1'b0;
         end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_cnt + COUNT_W'(edge_p & ~cnt_max);
            cnt_sat  <= cnt_sat | (edge_p & cnt_max);
         end
         if (term) begin
            latched_cnt <= edge_cnt + COUNT_W'(edge_p & ~cnt_max);
            lat_sat     <= cnt_sat | (edge_p & cnt_max);
         end
      end

   // multiplier FSM state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= nxt;

   // latch strobe starts the multiply; COUNT_W MUL cycles, then a single OUT cycle
   always_comb begin
      nxt = IDLE;
      if (state == IDLE)     nxt = lat_stb ? MUL : IDLE;
      else if (state == MUL) nxt = last ? OUT : MUL;
   end

   // LSB-first shift-add; the final partial sum is saturated straight into the result register
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc     <= '0;
         mc      <= '0;
         mp      <= '0;
         k       <= '0;
         res     <= '0;
         res_ovf <= 1'b0;
      end else if (state == IDLE && lat_stb) begin
         acc <= '0;
         mc  <= P'(SCALE);
         mp  <= latched_cnt;
         k   <= '0;
      end else if (state == MUL) begin
         acc <= acc_nxt;
         mc  <= mc << 1;
         mp  <= mp >> 1;
         k   <= k + 1'b1;
         if (last) begin
            res     <= prod_sat ? '1 : acc_nxt[RPM_W-1:0];
            res_ovf <= prod_sat | lat_sat;
         end
      end

`ifdef RPM_AVG_EN
   logic [2:0][RPM_W-1:0] hist;
   logic [2:0]            hist_ovf;
   logic [RPM_W+1:0]      sum;
   logic [RPM_W-1:0]      rpm_q;
   logic                  ovf_q, vld_q;

   assign sum = (RPM_W+2)'(res) + (RPM_W+2)'(hist[0]) + (RPM_W+2)'(hist[1]) + (RPM_W+2)'(hist[2]);

   // averaging stage: the fresh result joins three older ones and the truncated mean is registered
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hist     <= '0;
         hist_ovf <= '0;
         rpm_q    <= '0;
         ovf_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         vld_q <= state == OUT;
         if (state == OUT) begin
            hist     <= {hist[1:0], res};
            hist_ovf <= {hist_ovf[1:0], res_ovf};
            rpm_q    <= sum[RPM_W+1:2];
            ovf_q    <= res_ovf | (|hist_ovf);
         end
      end

   assign bus.rpm       = rpm_q;
   assign bus.overflow  = ovf_q;
   assign bus.rpm_valid = vld_q;
`else
   assign bus.rpm       = res;
   assign bus.overflow  = res_ovf;
   assign bus.rpm_valid = state == OUT;
`endif
   assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_rpm_meter.sv
// tb_rpm_meter: random Hall windows on an 11-bit and a 4-bit counter build, checked against an arithmetic speed model
module tb_rpm_meter;
   localparam int G  = 1000;
   localparam int SC = 10;
   localparam int RW = 11;
   localparam int RMAX = (1 << RW) - 1;

   typedef struct {
      int rpm;
      int ovf;
      int at;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic hall = 1'b0;
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;
   exp_t q11[$], q4[$];
   exp_t e11, e4;

   rpm_meter_if #(.RPM_W(RW)) b11 ();
   rpm_meter_if #(.RPM_W(RW)) b4 ();

   assign b11.en      = en;
   assign b11.hall_in = hall;
   assign b4.en       = en;
   assign b4.hall_in  = hall;

   rpm_meter #(.COUNT_W(11), .RPM_W(RW), .SCALE(SC), .GATE_CYCLES(G)) dut11 (.clk(clk), .rst(rst), .bus(b11));
   rpm_meter #(.COUNT_W(4), .RPM_W(RW), .SCALE(SC), .GATE_CYCLES(G)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int n, input int cw, input int at);
      exp_t r;
      int   cmax, c, p;
      cmax  = (1 << cw) - 1;
      c     = n > cmax ? cmax : n;
      p     = c * SC;
      r.rpm = p > RMAX ? RMAX : p;
      r.ovf = (n > cmax || p > RMAX) ? 1 : 0;
      r.at  = at;
      return r;
   endfunction

   always @(negedge clk)
      if (b11.rpm_valid) begin
         if (q11.size() == 0) chk("unexpected_valid_c11", 1, 0);
         else begin
            e11 = q11.pop_front();
            chk("rpm_c11", b11.rpm, e11.rpm);
            chk("ovf_c11", b11.overflow, e11.ovf);
            chk("latency_c11", cyc, e11.at);
            chk("busy_at_valid_c11", b11.busy, 1);
         end
      end

   always @(negedge clk)
      if (b4.rpm_valid) begin
         if (q4.size() == 0) chk("unexpected_valid_c4", 1, 0);
         else begin
            e4 = q4.pop_front();
            chk("rpm_c4", b4.rpm, e4.rpm);
            chk("ovf_c4", b4.overflow, e4.ovf);
            chk("latency_c4", cyc, e4.at);
         end
      end

   // one gate window: n edges mid-window, optionally one more whose pulse lands in the terminal cycle
   task automatic run_window(input int n, input bit on, input bit late, input bit push11, input bit push4);
      int p, pmax, t;
      pmax = n > 0 ? (G - 16) / n : 8;
      if (pmax > 8) pmax = 8;
      p = $urandom_range(pmax, 4);
      t = 0;
      en = on;
      for (int i = 0; i < G; i++) begin
         hall = (i >= 8 && (i - 8) / p < n && (i - 8) % p < 2) || (late && (i == G - 4 || i == G - 3));
         if (i == G - 1) t = cyc;
         @(posedge clk);
         #1;
      end
      if (on && push11) q11.push_back(model(n + int'(late), 11, t + 13));
      if (on && push4) q4.push_back(model(n + int'(late), 4, t + 6));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rpm", b11.rpm, 0);
      chk("reset_ovf", b11.overflow, 0);
      chk("reset_valid", b11.rpm_valid, 0);
      chk("reset_busy", b11.busy, 0);
      chk("reset_rpm_c4", b4.rpm, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_window(20, 1, 0, 1, 1);
      run_window(200, 1, 0, 1, 1);
      run_window(50, 0, 0, 1, 1);
      run_window(0, 1, 0, 1, 1);
      run_window(210, 1, 0, 1, 1);
      run_window(5, 1, 0, 1, 1);
      run_window(3, 1, 1, 1, 1);
      run_window(0, 1, 0, 1, 1);
      run_window(30, 1, 0, 0, 1);
      en   = 1'b0;
      hall = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("busy_in_mul", b11.busy, 1);
      rst = 1'b1;
      #1;
      chk("abort_rpm", b11.rpm, 0);
      chk("abort_ovf", b11.overflow, 0);
      chk("abort_busy", b11.busy, 0);
      chk("abort_rpm_c4", b4.rpm, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_window(7, 1, 0, 1, 1);
      repeat (14) begin
         int  n;
         bit  on, late;
         n    = $urandom_range(240, 0);
         on   = $urandom_range(5, 0) != 0;
         late = on && $urandom_range(1, 0) == 1;
         run_window(n, on, late, 1, 1);
      end
      en = 1'b0;
      for (int i = 0; i < 40 && (q11.size() != 0 || q4.size() != 0); i++) @(posedge clk);
      @(negedge clk);
      chk("drain_c11", q11.size(), 0);
      chk("drain_c4", q4.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
